i2c_reg_target: RTL and testbench



---
 rtl/i2c_reg_target.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
// I2C register target: 7-bit device address, 16-bit pointer, big-endian 16-bit words,
// pointer auto-increments by 2. Bus writes become wr_stb pulses; reads fetch via rd_stb/rd_data.
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h0A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_stb,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_stb,
  output logic [15:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic        busy
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_RX, ST_RX_ACK, ST_TX, ST_TX_ACK, ST_WAIT
  } state_t;

  state_t      state, state_d;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_q, sda_q, scl_s, sda_s;
  logic        scl_rise, scl_fall, start_ev, stop_ev;
  logic [3:0]  bit_cnt;
  logic [7:0]  rx_sr, rx_byte;
  logic [1:0]  byte_idx;
  logic [15:0] ptr, tx_sr;
  logic [7:0]  data_hi;
  logic        is_addr, ack_ph, tx_hi_done, rd_pend;

  // Bus idles high, so the synchronizers reset to 1 to avoid a false START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start_ev = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_ev  = scl_s & scl_q & ~sda_q & sda_s;
  assign rx_byte  = {rx_sr[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (start_ev)     state_d = ST_ADDR;
    else if (stop_ev) state_d = ST_IDLE;
    else begin
      case (state)
        ST_ADDR:
          if (scl_rise && bit_cnt == 4'd7) begin
            if (rx_byte[7:1] != DEV_ADDR) state_d = ST_WAIT;
            else if (rx_byte[0])          state_d = ST_TX_ACK;
            else                          state_d = ST_RX_ACK;
          end
        ST_RX:     if (scl_rise && bit_cnt == 4'd7) state_d = ST_RX_ACK;
        ST_RX_ACK: if (scl_fall && ack_ph) state_d = ST_RX;
        ST_TX:     if (scl_fall && bit_cnt == 4'd8) state_d = ST_TX_ACK;
        ST_TX_ACK: begin
          if (scl_rise && !is_addr && sda_s) state_d = ST_WAIT;
          else if (scl_fall && ack_ph)       state_d = ST_TX;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_oe     <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_stb     <= 1'b0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      byte_idx   <= '0;
      ptr        <= '0;
      tx_sr      <= '0;
      data_hi    <= '0;
      is_addr    <= 1'b0;
      ack_ph     <= 1'b0;
      tx_hi_done <= 1'b0;
      rd_pend    <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
      if (rd_pend) begin
        tx_sr   <= rd_data;
        rd_pend <= 1'b0;
      end
      if (start_ev) begin
        sda_oe     <= 1'b0;
        bit_cnt    <= '0;
        byte_idx   <= '0;
        is_addr    <= 1'b1;
        ack_ph     <= 1'b0;
        tx_hi_done <= 1'b0;
      end else if (stop_ev) begin
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        ack_ph <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_RX:
            if (scl_rise) begin
              rx_sr   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                ack_ph  <= 1'b0;
                if (state == ST_ADDR) busy <= (rx_byte[7:1] == DEV_ADDR);
              end
            end
          ST_RX_ACK:
            if (scl_fall) begin
              if (!ack_ph) begin
                sda_oe <= 1'b1;
                ack_ph <= 1'b1;
                if (!is_addr) begin
                  case (byte_idx)
                    2'd0: begin ptr[15:8] <= rx_sr; byte_idx <= 2'd1; end
                    2'd1: begin ptr[7:0]  <= rx_sr; byte_idx <= 2'd2; end
                    2'd2: begin data_hi   <= rx_sr; byte_idx <= 2'd3; end
                    default: begin
                      wr_stb   <= 1'b1;
                      wr_addr  <= ptr;
                      wr_data  <= {data_hi, rx_sr};
                      ptr      <= ptr + 16'd2;
                      byte_idx <= 2'd2;
                    end
                  endcase
                end
              end else begin
                sda_oe  <= 1'b0;
                ack_ph  <= 1'b0;
                is_addr <= 1'b0;
              end
            end
          ST_TX: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe     <= 1'b0;
                bit_cnt    <= '0;
                tx_hi_done <= ~tx_hi_done;
              end else begin
                sda_oe <= ~tx_sr[15];
                tx_sr  <= {tx_sr[14:0], 1'b0};
              end
            end
          end
          ST_TX_ACK: begin
            // Address ACK is our own; data ACKs come from the master.
            if (scl_rise) begin
              if (!is_addr && sda_s) begin
                sda_oe <= 1'b0;
                busy   <= 1'b0;
              end else begin
                ack_ph <= 1'b1;
                if (is_addr || !tx_hi_done) begin
                  rd_stb  <= 1'b1;
                  rd_addr <= ptr;
                  ptr     <= ptr + 16'd2;
                  rd_pend <= 1'b1;
                end
              end
            end else if (scl_fall) begin
              if (ack_ph) begin
                ack_ph  <= 1'b0;
                is_addr <= 1'b0;
                sda_oe  <= ~tx_sr[15];
                tx_sr   <= {tx_sr[14:0], 1'b0};
              end else if (is_addr) begin
                sda_oe <= 1'b1;
              end
            end
          end
          ST_WAIT: sda_oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master, queue-based register model,
// and a fabric responder; directed cases followed by randomized transactions.
module tb_i2c_reg_target;
  localparam int Q = 6;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
  logic        sda_line;
  logic        sda_oe, wr_stb, rd_stb, busy;
  logic [15:0] wr_addr, wr_data, rd_addr;
  logic [15:0] rd_data = 16'h0000;

  assign sda_line = m_sda & ~sda_oe;
  always #5 clk = ~clk;

  i2c_reg_target #(.DEV_ADDR(7'h0A)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_stb(rd_stb), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  int total = 0, bad = 0;
  logic [31:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [15:0] mptr = 16'h0000;
  logic [15:0] mem [logic [15:0]];
  bit no_oe = 1'b0, oe_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rdval(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[7:0] ^ 8'h5C, a[15:8] + 8'h31};
  endfunction

  // Per-cycle comparison of strobes against the model, plus the fabric read responder.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr_stb) begin
          if (exp_wr.size() == 0) chk("wr_stb_extra", 32'(wr_stb), 32'd0);
          else chk("wr_word", {wr_addr, wr_data}, exp_wr.pop_front());
        end
        if (rd_stb) begin
          if (exp_rd.size() == 0) chk("rd_stb_extra", 32'(rd_stb), 32'd0);
          else chk("rd_addr", 32'(rd_addr), 32'(exp_rd.pop_front()));
          rd_data = rdval(rd_addr);
        end
        if (no_oe && sda_oe && !oe_seen) begin
          oe_seen = 1'b1;
          chk("oe_on_mismatch", 32'(sda_oe), 32'd0);
        end
      end
    end
  endtask

  task automatic q(); repeat (Q) @(negedge clk); endtask
  task automatic bus_start(); m_sda = 1'b1; q(); scl = 1'b1; q(); m_sda = 1'b0; q(); scl = 1'b0; q(); endtask
  task automatic bus_stop();  m_sda = 1'b0; q(); scl = 1'b1; q(); m_sda = 1'b1; q(); endtask
  task automatic send_bit(input bit b); m_sda = b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q(); endtask
  task automatic clock_in(output bit b); q(); scl = 1'b1; q(); b = sda_line; q(); scl = 1'b0; q(); endtask

  task automatic write_byte(input logic [7:0] v, output bit ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    m_sda = 1'b1;
    clock_in(ack);
  endtask

  task automatic read_byte(input bit nack, output logic [7:0] v);
    bit b;
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin clock_in(b); v[i] = b; end
    send_bit(nack);
    m_sda = 1'b1;
  endtask

  // Model of a write body (bytes after the address byte).
  task automatic model_write(input bq_t b);
    for (int i = 0; i < b.size(); i++) begin
      if (i == 0) mptr[15:8] = b[i];
      else if (i == 1) mptr[7:0] = b[i];
      else if (i % 2 == 1) begin
        exp_wr.push_back({mptr, b[i-1], b[i]});
        mptr = mptr + 16'd2;
      end
    end
  endtask

  task automatic wr_txn(input logic [7:0] ab, input bq_t b, input bit matched);
    bit a;
    no_oe = !matched; oe_seen = 1'b0;
    bus_start();
    write_byte(ab, a);
    chk("addr_ack", 32'(a), 32'(!matched));
    foreach (b[i]) begin
      write_byte(b[i], a);
      chk("data_ack", 32'(a), 32'(!matched));
    end
    chk("busy_mid", 32'(busy), 32'(matched));
    bus_stop();
    chk("busy_stop", 32'(busy), 32'd0);
    chk("wr_missing", 32'(exp_wr.size()), 32'd0);
    no_oe = 1'b0;
  endtask

  task automatic rd_txn(input bit set_ptr, input logic [15:0] p, input int n, output bq_t got);
    bq_t expb;
    bit a;
    logic [7:0] v;
    logic [15:0] w;
    got = {};
    if (set_ptr) mptr = p;
    for (int j = 0; j < n; j++) begin
      w = rdval(mptr + 16'(2 * (j / 2)));
      expb.push_back((j % 2 == 1) ? w[7:0] : w[15:8]);
    end
    for (int k = 0; k < (n + 1) / 2; k++) exp_rd.push_back(mptr + 16'(2 * k));
    mptr = mptr + 16'(2 * ((n + 1) / 2));
    bus_start();
    if (set_ptr) begin
      write_byte(8'h14, a);   chk("ptr_ack", 32'(a), 32'd0);
      write_byte(p[15:8], a); chk("ptr_ack", 32'(a), 32'd0);
      write_byte(p[7:0], a);  chk("ptr_ack", 32'(a), 32'd0);
      bus_start();
    end
    write_byte(8'h15, a);
    chk("rd_addr_ack", 32'(a), 32'd0);
    for (int j = 0; j < n; j++) begin
      read_byte(j == n - 1, v);
      got.push_back(v);
      chk("rd_byte", 32'(v), 32'(expb[j]));
    end
    q();
    chk("sda_released", 32'(sda_oe), 32'd0);
    bus_stop();
    chk("rd_missing", 32'(exp_rd.size()), 32'd0);
    chk("busy_rd_stop", 32'(busy), 32'd0);
  endtask

  initial begin
    bq_t b, got;
    logic [7:0] ab;
    logic [6:0] r;
    logic [15:0] p;
    int k, n, kind;

    fork monitor(); join_none
    repeat (5) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("rst_rd_stb", 32'(rd_stb), 32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Pointer comes out of reset at 0.
    rd_txn(1'b0, 16'h0000, 1, got);

    b = '{8'h00, 8'h30, 8'h40, 8'h60};
    model_write(b);
    chk("pin_single", exp_wr[0], 32'h0030_4060);
    wr_txn(8'h14, b, 1'b1);
    chk("hold_wr_addr", 32'(wr_addr), 32'h0030);
    chk("hold_wr_data", 32'(wr_data), 32'h4060);

    b = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
    model_write(b);
    chk("pin_inc0", exp_wr[0], 32'h0002_1234);
    chk("pin_inc1", exp_wr[1], 32'h0004_5678);
    wr_txn(8'h14, b, 1'b1);

    b = '{8'h00, 8'h40, 8'h11, 8'h22};
    wr_txn(8'h16, b, 1'b0);

    b = '{8'h00, 8'h10, 8'hAB};
    model_write(b);
    chk("pin_abort", 32'(exp_wr.size()), 32'd0);
    wr_txn(8'h14, b, 1'b1);
    b = '{8'hFF, 8'hFE, 8'h11, 8'h22, 8'h33, 8'h44};
    model_write(b);
    chk("pin_wrap0", exp_wr[0], 32'hFFFE_1122);
    chk("pin_wrap1", exp_wr[1], 32'h0000_3344);
    wr_txn(8'h14, b, 1'b1);

    mem[16'h000A] = 16'hA011;
    mem[16'h000C] = 16'h5A5A;
    rd_txn(1'b1, 16'h000A, 4, got);
    chk("lit_b0", 32'(got[0]), 32'hA0);
    chk("lit_b1", 32'(got[1]), 32'h11);
    chk("lit_b2", 32'(got[2]), 32'h5A);
    chk("lit_b3", 32'(got[3]), 32'h5A);

    // Reset while the target is holding the address ACK.
    ab = 8'h14;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(ab[i]);
    m_sda = 1'b1;
    k = 0;
    while (!sda_oe && k < 40) begin @(negedge clk); k++; end
    chk("ack_before_rst", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_oe", 32'(sda_oe), 32'd0);
    rst = 1'b0;
    mptr = 16'h0000;
    exp_wr.delete();
    bus_stop();
    rd_txn(1'b0, 16'h0000, 2, got);

    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        r = 7'($urandom_range(0, 127));
        if (r == 7'h0A) r = 7'h0B;
        b = {};
        for (int i = 0; i < 3; i++) b.push_back(8'($urandom_range(0, 255)));
        wr_txn({r, 1'($urandom_range(0, 1))}, b, 1'b0);
      end else if (kind <= 5) begin
        p = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                        : 16'($urandom_range(0, 65535));
        b = '{p[15:8], p[7:0]};
        n = $urandom_range(0, 3);
        for (int i = 0; i < 2 * n; i++) b.push_back(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 2) == 0) b.push_back(8'($urandom_range(0, 255)));
        model_write(b);
        wr_txn(8'h14, b, 1'b1);
      end else begin
        p = 16'($urandom_range(0, 65535));
        rd_txn(1'($urandom_range(0, 1)), p, $urandom_range(1, 5), got);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
